// File: rtl/gpio_bank.sv
// gpio_bank: parameterised GPIO controller with per-pin direction, synchronised and
// optionally debounced inputs, edge-pending interrupts and a single-cycle register port.

module gpio_pin #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CNT_W   = 4
) (
  input  logic                 gclk,
  input  logic                 grst_n,
  input  logic                 pad,
  input  logic                 tick,
  input  logic                 deb_clr,
  input  logic [DEB_CNT_W-1:0] thr,
  output logic                 filt,
  output logic                 rise,
  output logic                 fall
);
  logic [SYNC_STAGES-1:0] sync;
  logic [DEB_CNT_W-1:0]   cnt, cnt_inc;
  logic                   sync_o, filt_q;

  assign sync_o  = sync[SYNC_STAGES-1];
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
  assign rise    = filt & ~filt_q;
  assign fall    = ~filt & filt_q;

  always_ff @(posedge gclk) begin
    if (!grst_n) begin
      sync   <= '0;
      cnt    <= '0;
      filt   <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], pad};
      filt_q <= filt;
      if (thr == '0) begin
        filt <= sync_o;
        cnt  <= '0;
      end else if (deb_clr || sync_o == filt) begin
        // agreement or a bounce back restarts the stability count
        cnt <= '0;
      end else if (tick) begin
        if (cnt_inc >= thr) begin
          filt <= sync_o;
          cnt  <= '0;
        end else begin
          cnt <= cnt_inc;
        end
      end
    end
  end
endmodule

module gpio_bank #(
  parameter int N_PINS      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int PRESC_W     = 16,
  parameter int DEB_CNT_W   = 4
) (
  input  logic              sys_clk_i,
  input  logic              rstn_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [4:0]        addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              ack_o,
  input  logic [N_PINS-1:0] gpio_val_i,
  output logic [N_PINS-1:0] gpio_val_o,
  output logic [N_PINS-1:0] gpio_dir_o,
  output logic              irq_o
);
  typedef enum logic [2:0] {
    R_DIR, R_OUT, R_IN, R_RISE, R_FALL, R_PEND, R_THR, R_TGL
  } reg_sel_e;

  typedef struct packed {
    logic        wr;
    logic        rd;
    reg_sel_e    sel;
    logic [31:0] wdata;
  } reg_req_t;

  reg_req_t             rq;
  logic [N_PINS-1:0]    dir_q, out_q, ren_q, fen_q, pend_q;
  logic [N_PINS-1:0]    dir_d, out_d, ren_d, fen_d, pend_d, clr;
  logic [N_PINS-1:0]    filt, rise, fall, wmask;
  logic [DEB_CNT_W-1:0] thr_q, thr_d;
  logic [PRESC_W-1:0]   presc_q;
  logic [31:0]          rd_mux;
  logic                 tick, thr_wr, unused_wdata;

  // only word-aligned addresses hit a register; byte offsets are unmapped
  assign rq.wr    = req_i && we_i && (addr_i[1:0] == 2'b00);
  assign rq.rd    = req_i && !we_i && (addr_i[1:0] == 2'b00);
  assign rq.sel   = reg_sel_e'(addr_i[4:2]);
  assign rq.wdata = wdata_i;

  assign wmask        = rq.wdata[N_PINS-1:0];
  assign tick         = &presc_q;
  assign thr_wr       = rq.wr && rq.sel == R_THR;
  assign unused_wdata = ^wdata_i;

  gpio_pin #(.SYNC_STAGES(SYNC_STAGES), .DEB_CNT_W(DEB_CNT_W)) u_pin [N_PINS-1:0] (
    .gclk    (sys_clk_i),
    .grst_n  (rstn_i),
    .pad     (gpio_val_i),
    .tick    (tick),
    .deb_clr (thr_wr),
    .thr     (thr_q),
    .filt    (filt),
    .rise    (rise),
    .fall    (fall)
  );

  always_comb begin
    dir_d = dir_q;
    out_d = out_q;
    ren_d = ren_q;
    fen_d = fen_q;
    thr_d = thr_q;
    clr   = '0;
    if (rq.wr) begin
      case (rq.sel)
        R_DIR:   dir_d = wmask;
        R_OUT:   out_d = wmask;
        R_RISE:  ren_d = wmask;
        R_FALL:  fen_d = wmask;
        R_PEND:  clr   = wmask;
        R_THR:   thr_d = rq.wdata[DEB_CNT_W-1:0];
        R_TGL:   out_d = out_q ^ wmask;
        default: ;
      endcase
    end
    // a fresh edge beats a simultaneous W1C
    pend_d = (pend_q & ~clr) | (rise & ren_q) | (fall & fen_q);
  end

  always_comb begin
    rd_mux = '0;
    case (rq.sel)
      R_DIR:   rd_mux[N_PINS-1:0]    = dir_q;
      R_OUT:   rd_mux[N_PINS-1:0]    = out_q;
      R_IN:    rd_mux[N_PINS-1:0]    = filt;
      R_RISE:  rd_mux[N_PINS-1:0]    = ren_q;
      R_FALL:  rd_mux[N_PINS-1:0]    = fen_q;
      R_PEND:  rd_mux[N_PINS-1:0]    = pend_q;
      R_THR:   rd_mux[DEB_CNT_W-1:0] = thr_q;
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (!rstn_i) begin
      dir_q   <= '0;
      out_q   <= '0;
      ren_q   <= '0;
      fen_q   <= '0;
      pend_q  <= '0;
      thr_q   <= '0;
      presc_q <= '0;
      irq_o   <= 1'b0;
      ack_o   <= 1'b0;
      rdata_o <= '0;
    end else begin
      dir_q   <= dir_d;
      out_q   <= out_d;
      ren_q   <= ren_d;
      fen_q   <= fen_d;
      pend_q  <= pend_d;
      thr_q   <= thr_d;
      presc_q <= presc_q + 1'b1;
      irq_o   <= |(pend_d & (ren_d | fen_d));
      ack_o   <= req_i;
      rdata_o <= rq.rd ? rd_mux : '0;
    end
  end

  assign gpio_dir_o = ~dir_q;
  assign gpio_val_o = out_q;
endmodule
